// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS bits, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Register select values taken from uart_i_addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  // STATUS/CTRL bit positions
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RXOVR    = 5;
  localparam int ST_FERR     = 6;
  localparam int ST_TXOVF    = 7;
  localparam int ST_RXIE     = 8;
  localparam int ST_TXIE     = 9;

  // Smallest divisor that still leaves room for the RX mid-bit sample
  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with separate pointer wrap and occupancy count.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, W1C sticky errors and a level interrupt.
// Latency: register reads return one cycle after the access; TX frame starts one cycle after the FIFO gets data.
// Backpressure: none on the bus; TX writes to a full FIFO are dropped (TXOVF), RX bytes into a full FIFO are dropped (RXOVR).
module uart_mmio
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_i_sel,
  input  logic [3:0]  uart_i_addr,
  input  logic [3:0]  uart_i_wmask,
  input  logic [31:0] uart_i_wdata,
  output logic [31:0] uart_o_rdata,
  output logic        uart_o_irq,
  input  logic        uart_i_rxd,
  output logic        uart_o_txd
);

  localparam logic [15:0] RST_DIV = 16'(CLK_HZ / BAUD);

  logic [1:0]  reg_sel;
  logic        wr_en, rd_en;
  logic [15:0] div_q, div_wr;
  logic        rxie, txie, txovf, rxovr, ferr;
  logic        tx_wr_req, tx_push, tx_pop, tx_full, tx_empty, tx_busy;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic [31:0] status_word;
  logic        unused_ok;

  uart_state_t tx_state, rx_state;
  logic [15:0] tx_cnt, tx_div, rx_cnt, rx_div;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_shreg, rx_shreg;
  logic        tx_bit_end, rx_bit_end, rx_mid;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_stop_ok, ferr_set, rxovr_set;

  assign reg_sel   = uart_i_addr[3:2];
  assign wr_en     = uart_i_sel & (uart_i_wmask != 4'd0);
  assign rd_en     = uart_i_sel & (uart_i_wmask == 4'd0);
  assign tx_wr_req = wr_en & (reg_sel == REG_TXDATA) & uart_i_wmask[0];
  assign tx_push   = tx_wr_req & ~tx_full;
  assign rx_pop    = rd_en & (reg_sel == REG_RXDATA) & ~rx_empty;
  assign unused_ok = ^{uart_i_addr[1:0], uart_i_wdata[31:16]};

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .push_dat(uart_i_wdata[7:0]), .pop(tx_pop),
    .head_dat(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_dat(rx_shreg), .pop(rx_pop),
    .head_dat(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Assemble STATUS and the byte-masked BAUD_DIV write value
  always_comb begin
    status_word              = '0;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_RX_FULL]  = rx_full;
    status_word[ST_RX_EMPTY] = rx_empty;
    status_word[ST_TX_BUSY]  = tx_busy;
    status_word[ST_RXOVR]    = rxovr;
    status_word[ST_FERR]     = ferr;
    status_word[ST_TXOVF]    = txovf;
    status_word[ST_RXIE]     = rxie;
    status_word[ST_TXIE]     = txie;
    div_wr = div_q;
    if (uart_i_wmask[0]) div_wr[7:0]  = uart_i_wdata[7:0];
    if (uart_i_wmask[1]) div_wr[15:8] = uart_i_wdata[15:8];
  end

  // Control bits and sticky flags; a same-cycle set wins over a W1C clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= RST_DIV;
      rxie  <= 1'b0;
      txie  <= 1'b0;
      txovf <= 1'b0;
      rxovr <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      if (wr_en && reg_sel == REG_STATUS && uart_i_wmask[0]) begin
        if (uart_i_wdata[ST_RXOVR]) rxovr <= 1'b0;
        if (uart_i_wdata[ST_FERR])  ferr  <= 1'b0;
        if (uart_i_wdata[ST_TXOVF]) txovf <= 1'b0;
      end
      if (wr_en && reg_sel == REG_STATUS && uart_i_wmask[1]) begin
        rxie <= uart_i_wdata[ST_RXIE];
        txie <= uart_i_wdata[ST_TXIE];
      end
      if (wr_en && reg_sel == REG_BAUD) div_q <= clamp_div(div_wr);
      if (tx_wr_req && tx_full) txovf <= 1'b1;
      if (rxovr_set) rxovr <= 1'b1;
      if (ferr_set)  ferr  <= 1'b1;
    end
  end

  // Registered read data (held between reads) and interrupt level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_o_rdata <= '0;
      uart_o_irq   <= 1'b0;
    end else begin
      uart_o_irq <= (~rx_empty & rxie) | (tx_empty & txie);
      if (rd_en) begin
        case (reg_sel)
          REG_TXDATA: uart_o_rdata <= {tx_full, 31'd0};
          REG_RXDATA: uart_o_rdata <= rx_empty ? 32'h8000_0000 : {24'd0, rx_head};
          REG_STATUS: uart_o_rdata <= status_word;
          default:    uart_o_rdata <= {16'd0, div_q};
        endcase
      end
    end
  end

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  assign tx_pop     = ~tx_empty & ((tx_state == IDLE) | ((tx_state == STOP) & tx_bit_end));
  assign tx_busy    = (tx_state != IDLE);

  // TX framer; STOP can chain straight into the next START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= IDLE;
      tx_cnt     <= '0;
      tx_div     <= RST_DIV;
      tx_bit     <= '0;
      tx_shreg   <= '0;
      uart_o_txd <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_state   <= START;
            tx_shreg   <= tx_head;
            tx_div     <= div_q;
            tx_cnt     <= '0;
            uart_o_txd <= 1'b0;
          end
        end
        START: begin
          if (tx_bit_end) begin
            tx_state   <= DATA;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            uart_o_txd <= tx_shreg[0];
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state   <= STOP;
              uart_o_txd <= 1'b1;
            end else begin
              tx_bit     <= tx_bit + 3'd1;
              tx_shreg   <= {1'b0, tx_shreg[7:1]};
              uart_o_txd <= tx_shreg[1];
            end
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_state   <= START;
              tx_shreg   <= tx_head;
              tx_div     <= div_q;
              uart_o_txd <= 1'b0;
            end else tx_state <= IDLE;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
      endcase
    end
  end

  assign rx_bit_end = (rx_cnt == rx_div - 16'd1);
  assign rx_mid     = (rx_cnt == {1'b0, rx_div[15:1]});
  assign rx_stop_ok = (rx_state == STOP) & rx_bit_end & rx_s2;
  assign ferr_set   = (rx_state == STOP) & rx_bit_end & ~rx_s2;
  assign rx_push    = rx_stop_ok & ~rx_full;
  assign rxovr_set  = rx_stop_ok & rx_full;

  // RX synchronizer, edge detect and mid-bit sampling framer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_div   <= RST_DIV;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      rx_s1   <= uart_i_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= START;
            rx_cnt   <= '0;
            rx_div   <= div_q;
          end
        end
        START: begin
          if (rx_mid) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: register access, TX framing, RX/loopback, overflow, glitch, framing error, reset.
// Latency: reads sampled one cycle after the access; serial lines sampled 1 ns after the clock edge.
// Backpressure: exercised through full TX/RX FIFOs.
`timescale 1ns/1ps
module tb_uart_mmio;

  localparam logic [3:0] A_TX = 4'h0;
  localparam logic [3:0] A_RX = 4'h4;
  localparam logic [3:0] A_ST = 4'h8;
  localparam logic [3:0] A_BD = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic        txd;
  logic        rxd_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rxd_line;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] d;
  logic [31:0] d2;
  logic [7:0]  b;
  logic [9:0]  frame_v;

  assign rxd_line = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_mmio #(.CLK_HZ(100_000_000), .BAUD(115200), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .uart_i_sel(sel), .uart_i_addr(addr), .uart_i_wmask(wmask), .uart_i_wdata(wdata),
    .uart_o_rdata(rdata), .uart_o_irq(irq),
    .uart_i_rxd(rxd_line), .uart_o_txd(txd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [7:0] e;
    if (exp_q.size() == 0) chk({tag, "_sb_underflow"}, exp_q.size(), 1);
    else begin
      e = exp_q.pop_front();
      chk(tag, got, {24'd0, e});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] v, input logic [3:0] m);
    @(posedge clk); #1;
    sel = 1'b1; addr = a; wdata = v; wmask = m;
    @(posedge clk); #1;
    sel = 1'b0; wmask = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    sel = 1'b1; addr = a; wmask = '0;
    @(posedge clk); #1;
    sel = 1'b0;
    v = rdata;
  endtask

  task automatic wait_txd_low(input string tag, input int max_cycles);
    int t = 0;
    while (txd !== 1'b0 && t < max_cycles) begin
      tick(1);
      t++;
    end
    if (t >= max_cycles) chk({tag, "_timeout"}, {31'd0, txd}, 0);
  endtask

  // Decode one 8N1 frame from txd by mid-bit sampling
  task automatic get_tx_byte(input int div, output logic [7:0] v);
    v = '0;
    wait_txd_low("tx_start", 20000);
    tick(div / 2);
    chk("tx_startbit", {31'd0, txd}, 0);
    for (int i = 0; i < 8; i++) begin
      tick(div);
      v[i] = txd;
    end
    tick(div);
    chk("tx_stopbit", {31'd0, txd}, 1);
  endtask

  task automatic send_rx_frame(input logic [7:0] v, input logic stop_bit);
    rxd_drv = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = v[i];
      tick(8);
    end
    rxd_drv = stop_bit;
    tick(8);
    rxd_drv = 1'b1;
    tick(4);
  endtask

  task automatic wait_rx_nonempty(input string tag);
    int t = 0;
    logic [31:0] s;
    s = 32'h8;
    while (s[3] && t < 150) begin
      bus_read(A_ST, s);
      t++;
    end
    if (t >= 150) chk({tag, "_timeout"}, s, 0);
  endtask

  // Global guard against a hung run
  initial begin
    #900_000;
    n_errors++;
    $display("FAIL watchdog: run still active, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_txd", {31'd0, txd}, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    rst = 1'b0;
    tick(2);
    bus_read(A_ST, d);
    chk("rst_status", d, 32'h0000_000A);
    bus_read(A_BD, d);
    chk("rst_baud", d, 32'd868);
    bus_write(A_BD, 32'd2, 4'hF);
    bus_read(A_BD, d);
    chk("baud_clamp", d, 32'd4);

    // Exact TX waveform of 0xA5 at 8 clocks per bit
    bus_write(A_BD, 32'd8, 4'hF);
    bus_write(A_TX, 32'hA5, 4'h1);
    frame_v = {1'b1, 8'hA5, 1'b0};
    wait_txd_low("t1_start", 50);
    fork
      begin
        for (int bi = 0; bi < 10; bi++)
          for (int c = 0; c < 8; c++) begin
            chk("t1_txd", {31'd0, txd}, {31'd0, frame_v[bi]});
            tick(1);
          end
      end
      begin
        tick(30);
        bus_read(A_ST, d2);
        chk("t1_busy", {31'd0, d2[4]}, 1);
      end
    join
    chk("t1_txd_idle", {31'd0, txd}, 1);
    tick(2);
    bus_read(A_ST, d);
    chk("t1_status_after", d, 32'h0000_000A);

    // TX FIFO overflow under a slow divisor
    bus_write(A_BD, 32'd64, 4'hF);
    bus_write(A_TX, 32'h01, 4'h1);
    exp_q.push_back(8'h01);
    fork
      begin
        for (int k = 0; k < 9; k++) begin
          get_tx_byte(64, b);
          sb_check("t2_txbyte", {24'd0, b});
        end
      end
      begin
        tick(4);
        for (int i = 0; i < 9; i++) begin
          bus_write(A_TX, 32'h11 + i, 4'h1);
          if (i < 8) exp_q.push_back(8'(8'h11 + i));
        end
        bus_read(A_TX, d2);
        chk("t2_txfull", d2, 32'h8000_0000);
        bus_read(A_ST, d2);
        chk("t2_txovf", {31'd0, d2[7]}, 1);
        bus_write(A_ST, 32'h80, 4'h1);
        bus_read(A_ST, d2);
        chk("t2_txovf_clr", {31'd0, d2[7]}, 0);
      end
    join
    chk("t2_sb_drained", exp_q.size(), 0);
    tick(200);
    chk("t2_no_extra_frame", {31'd0, txd}, 1);

    // Loopback of one byte
    bus_write(A_BD, 32'd8, 4'hF);
    loop_en = 1'b1;
    exp_q.push_back(8'h3C);
    bus_write(A_TX, 32'h3C, 4'h1);
    wait_rx_nonempty("t3_rx");
    bus_read(A_RX, d);
    sb_check("t3_rxdata", d);
    bus_read(A_RX, d);
    chk("t3_rx_empty_read", d, 32'h8000_0000);
    tick(20);
    loop_en = 1'b0;

    // Glitch rejection, then framing error
    rxd_drv = 1'b0;
    tick(2);
    rxd_drv = 1'b1;
    tick(30);
    bus_read(A_ST, d);
    chk("t4_glitch_empty", {31'd0, d[3]}, 1);
    chk("t4_glitch_ferr", {31'd0, d[6]}, 0);
    send_rx_frame(8'h55, 1'b0);
    tick(10);
    bus_read(A_ST, d);
    chk("t4_ferr", {31'd0, d[6]}, 1);
    chk("t4_ferr_empty", {31'd0, d[3]}, 1);
    bus_write(A_ST, 32'h40, 4'h1);
    bus_read(A_ST, d);
    chk("t4_ferr_clr", {31'd0, d[6]}, 0);

    // RX overflow, ordering and interrupt
    for (int i = 0; i < 9; i++) begin
      b = 8'(8'h30 + i * 7);
      send_rx_frame(b, 1'b1);
      if (i < 8) exp_q.push_back(b);
    end
    bus_read(A_ST, d);
    chk("t5_rxovr", {31'd0, d[5]}, 1);
    chk("t5_rxfull", {31'd0, d[2]}, 1);
    chk("t5_irq_off_before_ie", {31'd0, irq}, 0);
    bus_write(A_ST, 32'h100, 4'h2);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      chk("t5_irq_hold", {31'd0, irq}, 1);
      bus_read(A_RX, d);
      sb_check("t5_rxbyte", d);
    end
    tick(2);
    chk("t5_irq_off", {31'd0, irq}, 0);
    bus_read(A_RX, d);
    chk("t5_rx_empty_read", d, 32'h8000_0000);

    // Reset in the middle of the TX data phase
    bus_write(A_BD, 32'd8, 4'hF);
    bus_write(A_TX, 32'h00, 4'h1);
    bus_write(A_TX, 32'h7E, 4'h1);
    wait_txd_low("t6_start", 50);
    tick(26);
    chk("t6_pre_rst_txd", {31'd0, txd}, 0);
    #3 rst = 1'b1;
    #1 chk("t6_async_txd", {31'd0, txd}, 1);
    tick(2);
    rst = 1'b0;
    chk("t6_rdata", rdata, 0);
    chk("t6_irq", {31'd0, irq}, 0);
    tick(2);
    bus_read(A_TX, d);
    chk("t6_txdata", d, 0);
    bus_read(A_RX, d);
    chk("t6_rxdata", d, 32'h8000_0000);
    bus_read(A_ST, d);
    chk("t6_status", d, 32'h0000_000A);
    bus_read(A_BD, d);
    chk("t6_baud", d, 32'd868);
    tick(100);
    chk("t6_txd_idle", {31'd0, txd}, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
